cndm_core_ctrl: RTL

Parametrised core-level control block for the Corundum NIC datapath. It presents the core register window (identification, port geometry, scratch) on an AXI4-lite slave, and owns per-port interrupt gating with enable, pending latch, event counting and optional timer-based coalescing. It sits on interconnect output 0 in front of the per-port blocks, and drives the core `irq` vector in place of the raw port interrupts.

---
 rtl/cndm_core_ctrl_if.sv | 37 +++
 rtl/cndm_core_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cndm_core_ctrl_if.sv
// taxi_axil_if: AXI4-lite bundle split into write and read slave/master modports.
`default_nettype none

interface taxi_axil_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport wr_slv (input awaddr, awvalid, wdata, wstrb, wvalid, bready,
                    output awready, wready, bresp, bvalid);
    modport rd_slv (input araddr, arvalid, rready,
                    output arready, rdata, rresp, rvalid);
    modport wr_mst (output awaddr, awvalid, wdata, wstrb, wvalid, bready,
                    input awready, wready, bresp, bvalid);
    modport rd_mst (output araddr, arvalid, rready,
                    input arready, rdata, rresp, rvalid);
endinterface

`default_nettype wire

// File: rtl/cndm_core_ctrl.sv
// cndm_core_ctrl: core register window plus per-port IRQ gating/counting.
// Optional timer coalescing is built when CNDM_IRQ_COALESCE_EN is defined.
`default_nettype none

module cndm_core_ctrl #(
    parameter int          PORTS       = 2,
    parameter logic [31:0] PORT_BASE   = 32'h0001_0000,
    parameter logic [31:0] PORT_STRIDE = 32'h0001_0000,
    parameter int          PRESCALE    = 250,
    parameter int          TMR_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    taxi_axil_if.wr_slv      s_axil_wr,
    taxi_axil_if.rd_slv      s_axil_rd,
    input  logic [PORTS-1:0] irq_req,
    output logic [PORTS-1:0] irq
);
    localparam logic [31:0] ID      = 32'h434E_444D;
    localparam logic [31:0] VERSION = 32'h0000_0200;

    function automatic logic [15:0] port_addr(input int p, input int off);
        return 16'(32'h0200 + 32'(p) * 32'h10 + 32'(off));
    endfunction

    logic        bvalid_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [31:0] scratch_q;
    logic [31:0] rd_val;
    logic        wr_acc;
    logic        rd_acc;
    logic [15:0] waddr;
    logic [15:0] raddr;
    logic        tick;
    logic        unused_addr_bits;

    logic [PORTS-1:0][31:0] ctrl_rd;
    logic [PORTS-1:0][31:0] stat_rd;
    logic [PORTS-1:0][31:0] cnt_rd;

    assign wr_acc = s_axil_wr.awvalid && s_axil_wr.wvalid && !bvalid_q;
    assign rd_acc = s_axil_rd.arvalid && !rvalid_q;
    assign waddr  = {s_axil_wr.awaddr[15:2], 2'b00};
    assign raddr  = {s_axil_rd.araddr[15:2], 2'b00};
    assign unused_addr_bits = ^{s_axil_wr.awaddr, s_axil_rd.araddr};

    assign s_axil_wr.awready = wr_acc;
    assign s_axil_wr.wready  = wr_acc;
    assign s_axil_wr.bvalid  = bvalid_q;
    assign s_axil_wr.bresp   = 2'b00;
    assign s_axil_rd.arready = rd_acc;
    assign s_axil_rd.rvalid  = rvalid_q;
    assign s_axil_rd.rdata   = rdata_q;
    assign s_axil_rd.rresp   = 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            scratch_q <= '0;
        end else begin
            if (wr_acc) begin
                bvalid_q <= 1'b1;
            end else if (s_axil_wr.bready) begin
                bvalid_q <= 1'b0;
            end
            if (rd_acc) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
            end else if (s_axil_rd.rready) begin
                rvalid_q <= 1'b0;
            end
            if (wr_acc && waddr == 16'h0110) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_axil_wr.wstrb[b]) scratch_q[8*b +: 8] <= s_axil_wr.wdata[8*b +: 8];
                end
            end
        end
    end

    // Per-port registers are muxed in after the fixed map; windows never overlap.
    always_comb begin
        rd_val = '0;
        case (raddr)
            16'h0000: rd_val = ID;
            16'h0004: rd_val = VERSION;
            16'h0100: rd_val = 32'(PORTS);
            16'h0104: rd_val = PORT_BASE;
            16'h0108: rd_val = PORT_STRIDE;
            16'h0110: rd_val = scratch_q;
            default:  rd_val = '0;
        endcase
        for (int p = 0; p < PORTS; p++) begin
            if (raddr == port_addr(p, 0)) rd_val = ctrl_rd[p];
            if (raddr == port_addr(p, 4)) rd_val = stat_rd[p];
            if (raddr == port_addr(p, 8)) rd_val = cnt_rd[p];
        end
    end

`ifdef CNDM_IRQ_COALESCE_EN
    localparam int PS_W = $clog2(PRESCALE);
    logic [PS_W-1:0] ps_q;

    assign tick = (ps_q == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q <= '0;
        end else if (tick) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_q + 1'b1;
        end
    end
`else
    assign tick = 1'b0;
`endif

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        localparam logic [15:0] BASE = port_addr(p, 0);

        typedef enum logic [1:0] {
            ST_IDLE = 2'd0,
            ST_FIRE = 2'd1,
            ST_HOLD = 2'd2
        } state_t;

        state_t      state_q;
        logic        en_q;
        logic        pend_q;
        logic        irq_q;
        logic [31:0] count_q;
        logic        wr_ctrl;
        logic        wr_stat;
        logic        wr_cnt;
        logic        en_d;
        logic        pend_clr;

        assign wr_ctrl  = wr_acc && waddr == BASE;
        assign wr_stat  = wr_acc && waddr == BASE + 16'h4;
        assign wr_cnt   = wr_acc && waddr == BASE + 16'h8;
        assign en_d     = s_axil_wr.wstrb[0] ? s_axil_wr.wdata[0] : en_q;
        assign pend_clr = (state_q == ST_FIRE) ||
                          (wr_stat && s_axil_wr.wstrb[0] && s_axil_wr.wdata[0]);
        assign irq[p]   = irq_q;
        assign cnt_rd[p] = count_q;

`ifdef CNDM_IRQ_COALESCE_EN
        logic [TMR_W-1:0] holdoff_q;
        logic [TMR_W-1:0] timer_q;
        logic [15:0]      hold_cur;
        logic [15:0]      hold_d;

        assign hold_cur   = 16'(holdoff_q);
        assign hold_d     = {s_axil_wr.wstrb[3] ? s_axil_wr.wdata[31:24] : hold_cur[15:8],
                             s_axil_wr.wstrb[2] ? s_axil_wr.wdata[23:16] : hold_cur[7:0]};
        assign ctrl_rd[p] = {hold_cur, 15'd0, en_q};
        assign stat_rd[p] = {30'd0, state_q == ST_HOLD, pend_q};
`else
        assign ctrl_rd[p] = {31'd0, en_q};
        assign stat_rd[p] = {31'd0, pend_q};
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                en_q    <= 1'b0;
                pend_q  <= 1'b0;
                irq_q   <= 1'b0;
                count_q <= '0;
`ifdef CNDM_IRQ_COALESCE_EN
                holdoff_q <= '0;
                timer_q   <= '0;
`endif
            end else begin
                irq_q <= 1'b0;
                if (wr_ctrl) begin
                    en_q <= en_d;
`ifdef CNDM_IRQ_COALESCE_EN
                    holdoff_q <= hold_d[TMR_W-1:0];
`endif
                end
                if (wr_cnt) begin
                    count_q <= '0;
                end else if (irq_req[p] && count_q != 32'hFFFF_FFFF) begin
                    count_q <= count_q + 32'd1;
                end
                // A new event always beats a clear in the same cycle.
                if (irq_req[p]) begin
                    pend_q <= 1'b1;
                end else if (pend_clr) begin
                    pend_q <= 1'b0;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (pend_q && en_q) begin
                            state_q <= ST_FIRE;
                            irq_q   <= 1'b1;
                        end
                    end
                    ST_FIRE: begin
`ifdef CNDM_IRQ_COALESCE_EN
                        timer_q <= holdoff_q;
                        state_q <= ST_HOLD;
`else
                        state_q <= ST_IDLE;
`endif
                    end
                    ST_HOLD: begin
`ifdef CNDM_IRQ_COALESCE_EN
                        if (timer_q == '0) begin
                            state_q <= ST_IDLE;
                        end else if (tick) begin
                            timer_q <= timer_q - 1'b1;
                        end
`else
                        state_q <= ST_IDLE;
`endif
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
